// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetch stage for the BeeF core.
// A registered fetch pc drives a 1-cycle-latency instruction ROM. Returning words and
// their addresses land in a DEPTH-entry prefetch FIFO, and the FIFO head is offered
// to decode through a valid/ready handshake. The stage also handles redirects
// (flush and restart), NOP substitution while a bracket search is active, and a
// one-cycle delay bubble.
// Optional feature: define IFQ_BYPASS_EN so that ROM data can reach the outputs in the
// same cycle it returns, but only while the FIFO is empty.
module instruction_fetch_queue #(
  parameter int              IW       = 9,
  parameter int              AW       = 16,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [IW-1:0]   NOP      = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [AW-1:0]              imem_addr,
  input  logic [IW-1:0]              imem_data,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  input  logic                       searching,
  input  logic                       delay,
  input  logic                       delayed_op,
  input  logic                       ready,
  output logic                       valid,
  output logic [IW-1:0]              instruction,
  output logic [AW-1:0]              inst_pc,
  output logic                       delay_op,
  output logic                       delayed,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fpc_q, fpc_d;
  logic          infl_q, infl_d;
  logic [AW-1:0] infl_addr_q, infl_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          delayed_q, delayed_d;
  logic          delay_op_q, delay_op_d;
  logic [IW-1:0] instr_mem_q [DEPTH];
  logic [IW-1:0] instr_mem_d [DEPTH];
  logic [AW-1:0] pc_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_d [DEPTH];

  logic          fifo_empty;
  logic          bypass;
  logic          valid_int;
  logic [IW-1:0] head_instr;
  logic [AW-1:0] head_pc;
  logic          pop;
  logic          fifo_pop;
  logic          push;
  logic [CW-1:0] level;
  logic          issue;

  // Handshake decode: head selection, pop/push/issue qualification.
  always_comb begin
    fifo_empty = (count_q == '0);
    bypass     = 1'b0;
`ifdef IFQ_BYPASS_EN
    // Returning data is only shown directly when nothing older is queued and a
    // redirect is not throwing it away this cycle.
    bypass     = fifo_empty & infl_q & ~redirect;
`endif
    valid_int  = ~fifo_empty | bypass;
    head_instr = bypass ? imem_data   : instr_mem_q[rd_ptr_q];
    head_pc    = bypass ? infl_addr_q : pc_mem_q[rd_ptr_q];
    pop        = valid_int & ready & ~delayed_q & ~redirect;
    fifo_pop   = pop & ~bypass;
    // A bypassed word that is consumed in its arrival cycle never enters the FIFO.
    push       = infl_q & ~redirect & ~(bypass & pop);
    // Counting the in-flight request reserves its slot, so the FIFO cannot overflow.
    level      = count_q + CW'(infl_q);
    issue      = ~redirect & (level < CW'(DEPTH));
  end

  // Next-state computation for fetch pc, in-flight tracking, FIFO pointers and bubble.
  always_comb begin
    fpc_d       = fpc_q;
    infl_d      = issue;
    infl_addr_d = infl_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    delayed_d   = delay;
    delay_op_d  = delay ? delayed_op : delay_op_q;
    if (redirect) begin
      fpc_d    = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        fpc_d       = fpc_q + AW'(1);
        infl_addr_d = fpc_q;
      end
      if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
      if (fifo_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(fifo_pop);
    end
  end

  // FIFO storage write port.
  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (push) begin
      instr_mem_d[wr_ptr_q] = imem_data;
      pc_mem_d[wr_ptr_q]    = infl_addr_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q       <= RESET_PC;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      delayed_q   <= 1'b0;
      delay_op_q  <= 1'b0;
    end else begin
      fpc_q       <= fpc_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      delayed_q   <= delayed_d;
      delay_op_q  <= delay_op_d;
    end
  end

  // FIFO storage; contents are qualified by count/pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  // Output drive: NOP whenever nothing is valid, a search is active or a bubble is shown.
  always_comb begin
    imem_addr   = fpc_q;
    valid       = valid_int;
    instruction = (valid_int & ~searching & ~delayed_q) ? head_instr : NOP;
    inst_pc     = valid_int ? head_pc : '0;
    delayed     = delayed_q;
    delay_op    = delay_op_q;
    occupancy   = count_q;
  end

endmodule
